// File: rtl/bs_pkg.sv
// bs_pkg: shared TAP state encodings, opcode constants and IDCODE width
package bs_pkg;
  localparam int IDCODE_W = 32;
  localparam logic [3:0] OP_EXTEST = 4'b0000;
  localparam logic [3:0] OP_SAMPLE = 4'b0001;
  localparam logic [3:0] OP_IDCODE = 4'b0010;
  localparam logic [3:0] OP_BYPASS = 4'b1111;
  typedef enum logic [3:0] {
    EX2_DR   = 4'h0,
    EX1_DR   = 4'h1,
    SH_DR    = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EX2_IR   = 4'h8,
    EX1_IR   = 4'h9,
    SH_IR    = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } tap_state_t;
endpackage

// File: rtl/bs_tap_fsm.sv
// bs_tap_fsm: 16-state TAP state register and next-state logic; in ClockBR, RstBar, tms; out state, next_state
module bs_tap_fsm import bs_pkg::*; (
  input  logic       ClockBR,
  input  logic       RstBar,
  input  logic       tms,
  output tap_state_t state,
  output tap_state_t next_state
);
  always_ff @(posedge ClockBR or negedge RstBar)
    if (!RstBar) state <= TLR;
    else state <= next_state;
  always_comb begin
    next_state = TLR;
    unique case (state)
      TLR:      next_state = tms ? TLR    : RTI;
      RTI:      next_state = tms ? SEL_DR : RTI;
      SEL_DR:   next_state = tms ? SEL_IR : CAP_DR;
      CAP_DR:   next_state = tms ? EX1_DR : SH_DR;
      SH_DR:    next_state = tms ? EX1_DR : SH_DR;
      EX1_DR:   next_state = tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: next_state = tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   next_state = tms ? UPD_DR : SH_DR;
      UPD_DR:   next_state = tms ? SEL_DR : RTI;
      SEL_IR:   next_state = tms ? TLR    : CAP_IR;
      CAP_IR:   next_state = tms ? EX1_IR : SH_IR;
      SH_IR:    next_state = tms ? EX1_IR : SH_IR;
      EX1_IR:   next_state = tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: next_state = tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   next_state = tms ? UPD_IR : SH_IR;
      UPD_IR:   next_state = tms ? SEL_DR : RTI;
    endcase
  end
endmodule

// File: rtl/bs_tap_controller.sv
// bs_tap_controller: IEEE 1149.1 TAP with IR, bypass/IDCODE DRs and BSR chain controls; in ClockBR, RstBar, TMS, TDI, BsrSO; out TDO, TdoEn, ShiftBR, ClockEnBR, UpdateBR, ModeControl, TapState, IrOut
module bs_tap_controller import bs_pkg::*; #(
  parameter int                  IR_W       = 4,
  parameter logic [IDCODE_W-1:0] IDCODE_VAL = 32'h1000_0001,
  parameter logic [IR_W-1:0]     OP_EXTEST  = IR_W'(bs_pkg::OP_EXTEST),
  parameter logic [IR_W-1:0]     OP_SAMPLE  = IR_W'(bs_pkg::OP_SAMPLE),
  parameter logic [IR_W-1:0]     OP_IDCODE  = IR_W'(bs_pkg::OP_IDCODE),
  parameter logic [IR_W-1:0]     OP_BYPASS  = '1
) (
  input  logic            ClockBR,
  input  logic            RstBar,
  input  logic            TMS,
  input  logic            TDI,
  input  logic            BsrSO,
  output logic            TDO,
  output logic            TdoEn,
  output logic            ShiftBR,
  output logic            ClockEnBR,
  output logic            UpdateBR,
  output logic            ModeControl,
  output logic [3:0]      TapState,
  output logic [IR_W-1:0] IrOut
);
  tap_state_t state, next_state;
  logic [IR_W-1:0] ir, ir_sr;
  logic byp;
  logic [IDCODE_W-1:0] id_sr;
  logic sel_bsr, sel_id;
  bs_tap_fsm u_fsm (
    .ClockBR    (ClockBR),
    .RstBar     (RstBar),
    .tms        (TMS),
    .state      (state),
    .next_state (next_state)
  );
  always_ff @(posedge ClockBR or negedge RstBar)
    if (!RstBar) begin
      ir    <= OP_IDCODE;
      ir_sr <= '0;
      byp   <= 1'b0;
      id_sr <= IDCODE_VAL;
    end else begin
      if (state == CAP_IR) ir_sr <= IR_W'(2'b01);
      else if (state == SH_IR) ir_sr <= {TDI, ir_sr[IR_W-1:1]};
      if (next_state == TLR) ir <= OP_IDCODE;
      else if (state == UPD_IR) ir <= ir_sr;
      if (state == CAP_DR) begin
        byp   <= 1'b0;
        id_sr <= IDCODE_VAL;
      end else if (state == SH_DR) begin
        byp   <= TDI;
        id_sr <= {TDI, id_sr[IDCODE_W-1:1]};
      end
    end
  // Undefined opcodes and OP_BYPASS both fall through to the bypass register.
  always_comb begin
    sel_bsr     = (ir == OP_EXTEST) || (ir == OP_SAMPLE);
    sel_id      = (ir == OP_IDCODE) && (ir != OP_BYPASS);
    TdoEn       = (state == SH_DR) || (state == SH_IR);
    ShiftBR     = sel_bsr && (state == SH_DR);
    ClockEnBR   = sel_bsr && ((state == CAP_DR) || (state == SH_DR));
    UpdateBR    = sel_bsr && (state == UPD_DR);
    ModeControl = (ir == OP_EXTEST);
    TDO         = (state == SH_IR) ? ir_sr[0] :
                  (state == SH_DR) ? (sel_bsr ? BsrSO : sel_id ? id_sr[0] : byp) : 1'b0;
    TapState    = state;
    IrOut       = ir;
  end
endmodule

// File: tb/tb_bs_tap_controller.sv
// tb_bs_tap_controller: table, directed and random-vs-model checks of bs_tap_controller
module tb_bs_tap_controller;
  logic ClockBR = 1'b0, RstBar = 1'b0, TMS = 1'b1, TDI = 1'b0, BsrSO = 1'b0;
  logic TDO, TdoEn, ShiftBR, ClockEnBR, UpdateBR, ModeControl;
  logic [3:0] TapState, IrOut;
  int checks = 0, errors = 0;
  bs_tap_controller dut (
    .ClockBR(ClockBR), .RstBar(RstBar), .TMS(TMS), .TDI(TDI), .BsrSO(BsrSO),
    .TDO(TDO), .TdoEn(TdoEn), .ShiftBR(ShiftBR), .ClockEnBR(ClockEnBR),
    .UpdateBR(UpdateBR), .ModeControl(ModeControl), .TapState(TapState), .IrOut(IrOut)
  );
  always #5 ClockBR = ~ClockBR;
  // next-state tables indexed by the state encoding, taken straight from the transition list
  int nx0[16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
  int nx1[16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};
  int m_st;
  logic [3:0] m_ir, m_irsr;
  logic m_byp;
  logic [31:0] m_id;
  typedef struct {
    logic tms, tdi, bso, tdo, en, sh, ce, up, mc;
    logic [3:0] nst, ir;
  } vec_t;
  vec_t tbl[19];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic m_reset();
    m_st = 15; m_ir = 4'h2; m_irsr = 4'h0; m_byp = 1'b0; m_id = 32'h1000_0001;
  endtask
  task automatic m_step(input logic tms, input logic tdi);
    int st = m_st;
    if (st == 14) m_irsr = 4'b0001;
    else if (st == 10) m_irsr = {tdi, m_irsr[3:1]};
    if (st == 6) begin m_byp = 1'b0; m_id = 32'h1000_0001; end
    else if (st == 2) begin m_byp = tdi; m_id = {tdi, m_id[31:1]}; end
    m_st = tms ? nx1[st] : nx0[st];
    if (m_st == 15) m_ir = 4'h2;
    else if (st == 13) m_ir = m_irsr;
  endtask
  task automatic m_check();
    logic sb = (m_ir == 4'h0) || (m_ir == 4'h1);
    logic e_tdo = (m_st == 10) ? m_irsr[0] :
                  (m_st == 2) ? (sb ? BsrSO : (m_ir == 4'h2) ? m_id[0] : m_byp) : 1'b0;
    chk("rnd_state", 32'(TapState), 32'(m_st));
    chk("rnd_ir", 32'(IrOut), 32'(m_ir));
    chk("rnd_tdo", 32'(TDO), 32'(e_tdo));
    chk("rnd_tdoen", 32'(TdoEn), 32'((m_st == 2) || (m_st == 10)));
    chk("rnd_shift", 32'(ShiftBR), 32'(sb && m_st == 2));
    chk("rnd_clken", 32'(ClockEnBR), 32'(sb && (m_st == 2 || m_st == 6)));
    chk("rnd_update", 32'(UpdateBR), 32'(sb && m_st == 5));
    chk("rnd_mode", 32'(ModeControl), 32'(m_ir == 4'h0));
  endtask
  task automatic tick(input logic tms, input logic tdi);
    TMS = tms; TDI = tdi;
    @(posedge ClockBR);
    #1;
    if (RstBar) m_step(tms, tdi);
  endtask
  task automatic read_id(output logic [31:0] v);
    tick(0, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 32; i++) begin
      v[i] = TDO;
      tick(i == 31, 0);
    end
  endtask
  task automatic load_ir(input logic [3:0] op);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 4; i++) tick(i == 3, op[i]);
    tick(1, 0); tick(0, 0);
  endtask
  initial begin
    logic [31:0] v;
    logic [2:0] pat;
    tbl[0]  = '{1,0,0, 0,0,0,0,0,0, 4'h5, 4'h2};
    tbl[1]  = '{1,0,0, 0,0,0,0,0,0, 4'h7, 4'h2};
    tbl[2]  = '{1,0,0, 0,0,0,0,0,0, 4'h4, 4'h2};
    tbl[3]  = '{0,0,0, 0,0,0,0,0,0, 4'hE, 4'h2};
    tbl[4]  = '{0,0,0, 0,0,0,0,0,0, 4'hA, 4'h2};
    tbl[5]  = '{0,0,0, 1,1,0,0,0,0, 4'hA, 4'h2};
    tbl[6]  = '{0,0,0, 0,1,0,0,0,0, 4'hA, 4'h2};
    tbl[7]  = '{0,0,0, 0,1,0,0,0,0, 4'hA, 4'h2};
    tbl[8]  = '{1,0,0, 0,1,0,0,0,0, 4'h9, 4'h2};
    tbl[9]  = '{1,0,0, 0,0,0,0,0,0, 4'hD, 4'h2};
    tbl[10] = '{1,0,0, 0,0,0,0,0,0, 4'h7, 4'h0};
    tbl[11] = '{0,0,0, 0,0,0,0,0,1, 4'h6, 4'h0};
    tbl[12] = '{0,0,0, 0,0,0,1,0,1, 4'h2, 4'h0};
    tbl[13] = '{0,1,1, 1,1,1,1,0,1, 4'h2, 4'h0};
    tbl[14] = '{0,0,0, 0,1,1,1,0,1, 4'h2, 4'h0};
    tbl[15] = '{1,0,1, 1,1,1,1,0,1, 4'h1, 4'h0};
    tbl[16] = '{1,0,0, 0,0,0,0,0,1, 4'h5, 4'h0};
    tbl[17] = '{0,0,0, 0,0,0,0,1,1, 4'hC, 4'h0};
    tbl[18] = '{0,0,0, 0,0,0,0,0,1, 4'hC, 4'h0};
    repeat (2) @(posedge ClockBR);
    #1;
    m_reset();
    chk("rst_state", 32'(TapState), 32'hF);
    chk("rst_ir", 32'(IrOut), 32'h2);
    chk("rst_tdo", 32'(TDO), 32'h0);
    chk("rst_strobes", 32'({TdoEn, ShiftBR, ClockEnBR, UpdateBR, ModeControl}), 32'h0);
    RstBar = 1'b1;
    tick(0, 0);
    repeat (5) tick(1, 0);
    chk("tlr5_state", 32'(TapState), 32'hF);
    chk("tlr5_ir", 32'(IrOut), 32'h2);
    chk("tlr5_en_mode", 32'({TdoEn, ModeControl}), 32'h0);
    read_id(v);
    chk("idcode_stream", v, 32'h1000_0001);
    chk("idcode_end_state", 32'(TapState), 32'h1);
    for (int i = 0; i < 19; i++) begin
      TMS = tbl[i].tms; TDI = tbl[i].tdi; BsrSO = tbl[i].bso;
      #1;
      chk($sformatf("tbl%0d_tdo", i), 32'(TDO), 32'(tbl[i].tdo));
      chk($sformatf("tbl%0d_en", i), 32'(TdoEn), 32'(tbl[i].en));
      chk($sformatf("tbl%0d_shift", i), 32'(ShiftBR), 32'(tbl[i].sh));
      chk($sformatf("tbl%0d_clken", i), 32'(ClockEnBR), 32'(tbl[i].ce));
      chk($sformatf("tbl%0d_update", i), 32'(UpdateBR), 32'(tbl[i].up));
      chk($sformatf("tbl%0d_mode", i), 32'(ModeControl), 32'(tbl[i].mc));
      tick(tbl[i].tms, tbl[i].tdi);
      chk($sformatf("tbl%0d_state", i), 32'(TapState), 32'(tbl[i].nst));
      chk($sformatf("tbl%0d_ir", i), 32'(IrOut), 32'(tbl[i].ir));
    end
    BsrSO = 1'b0;
    load_ir(4'hF);
    chk("byp_ir", 32'(IrOut), 32'hF);
    chk("byp_mode", 32'(ModeControl), 32'h0);
    tick(1, 0); tick(0, 0); tick(0, 0);
    pat = 3'b101;
    for (int i = 0; i < 3; i++) begin
      TDI = pat[2-i];
      #1;
      chk($sformatf("byp_tdo%0d", i), 32'(TDO), 32'(i == 1));
      chk($sformatf("byp_ctl%0d", i), 32'({ShiftBR, ClockEnBR}), 32'h0);
      tick(i == 2, pat[2-i]);
    end
    tick(1, 0); tick(0, 0);
    load_ir(4'h0);
    chk("ext_mode", 32'(ModeControl), 32'h1);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0); tick(0, 1); tick(0, 0);
    chk("midir_state", 32'(TapState), 32'hA);
    #2;
    RstBar = 1'b0;
    #1;
    chk("arst_state", 32'(TapState), 32'hF);
    chk("arst_ir", 32'(IrOut), 32'h2);
    chk("arst_en", 32'(TdoEn), 32'h0);
    chk("arst_mode", 32'(ModeControl), 32'h0);
    m_reset();
    @(posedge ClockBR);
    #1;
    RstBar = 1'b1;
    read_id(v);
    chk("arst_idcode", v, 32'h1000_0001);
    tick(1, 0);
    repeat (5) tick(1, 0);
    for (int i = 0; i < 2000; i++) begin
      logic t = ($urandom_range(0, 3) == 0);
      logic d = 1'($urandom);
      TMS = t; TDI = d; BsrSO = 1'($urandom);
      #1;
      m_check();
      tick(t, d);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bs_tap_controller.md
Name: bs_tap_controller

Overview:
- IEEE 1149.1 TAP controller that sequences the chain of 1-bit boundary-scan cells in this design.
- Runs the 16-state TAP FSM and holds the instruction register (IR).
- Holds the bypass and IDCODE data registers and drives the TDO mux.
- Generates the chain controls: shift select, capture/shift clock enable, update strobe and mode control.
- Sits between the test pins and the boundary-scan register chain.

Parameters:
- IR_W, 4, instruction register width (minimum 2).
- IDCODE_VAL, 32'h1000_0001, value captured by the IDCODE register (bit 0 must be 1).
- OP_EXTEST, 4'b0000, EXTEST opcode.
- OP_SAMPLE, 4'b0001, SAMPLE/PRELOAD opcode.
- OP_IDCODE, 4'b0010, IDCODE opcode.
- OP_BYPASS, all ones, BYPASS opcode. Any undefined opcode behaves as BYPASS.

Ports:
- ClockBR  in  1  test clock; all state changes on rising edge.
- RstBar  in  1  asynchronous active-low reset.
- TMS  in  1  test mode select, sampled on the rising edge.
- TDI  in  1  test data in; also forwarded to the chain serial input by the integrator.
- BsrSO  in  1  serial out of the last boundary-scan cell.
- TDO  out  1  test data out.
- TdoEn  out  1  high only in Shift-DR or Shift-IR.
- ShiftBR  out  1  chain shift select.
- ClockEnBR  out  1  chain clock enable (capture or shift).
- UpdateBR  out  1  chain update strobe.
- ModeControl  out  1  chain output mux select.
- TapState  out  4  current TAP state encoding.
- IrOut  out  IR_W  current active instruction.

Behaviour:
- Reset (RstBar low, asynchronous):
  - state = Test-Logic-Reset (TLR).
  - IR = OP_IDCODE; IR shift reg = 0; bypass reg = 0; IDCODE shift reg = IDCODE_VAL.
  - All strobes 0; TDO = 0; TdoEn = 0; ModeControl = 0.
- FSM state encodings (hex), with next state for TMS=0 / TMS=1:
  - TLR F: RTI / TLR
  - RTI C: RTI / SelDR
  - SelDR 7: CapDR / SelIR
  - CapDR 6: ShDR / Ex1DR
  - ShDR 2: ShDR / Ex1DR
  - Ex1DR 1: PauseDR / UpdDR
  - PauseDR 3: PauseDR / Ex2DR
  - Ex2DR 0: ShDR / UpdDR
  - UpdDR 5: RTI / SelDR
  - SelIR 4: CapIR / TLR
  - CapIR E: ShIR / Ex1IR
  - ShIR A: ShIR / Ex1IR
  - Ex1IR 9: PauseIR / UpdIR
  - PauseIR B: PauseIR / Ex2IR
  - Ex2IR 8: ShIR / UpdIR
  - UpdIR D: RTI / SelDR
- Five consecutive TMS=1 edges reach TLR from any state.
- Entering TLR synchronously loads IR = OP_IDCODE.
- IR path:
  - CapIR: IR shift reg <= {0..., 2'b01}.
  - ShIR: shift right, TDI into MSB.
  - UpdIR: IR <= IR shift reg; IrOut changes on that edge.
- DR select is decoded from IR: EXTEST or SAMPLE selects BSR; IDCODE selects IDCODE reg; everything else selects bypass.
- Bypass reg: CapDR loads 0; ShDR loads TDI.
- IDCODE reg: CapDR loads IDCODE_VAL; ShDR shifts right, TDI into bit 31.
- Chain control outputs, decoded from the registered state, glitch-free:
  - ShiftBR = selBSR & (state==ShDR).
  - ClockEnBR = selBSR & (state==CapDR | state==ShDR).
  - UpdateBR = selBSR & (state==UpdDR); exactly one cycle per visit.
- ModeControl = (IR==OP_EXTEST), updated only at UpdIR or TLR.
- TDO:
  - Combinational mux: ShIR gives IR shift reg[0]; ShDR gives the selected DR bit 0 (BsrSO for BSR); otherwise 0.
  - TdoEn is high only in the shift states.
  - Bit shifted out on an edge is the value present before that edge.
- Pause states hold all shift registers unchanged.
- Reset mid-shift: all contents are discarded and ModeControl drops to 0 immediately.

Decomposition:
- Shared package bs_pkg holds:
  - tap_state_t enum with the 16 encodings above.
  - opcode constants OP_*.
  - IDCODE_W = 32.
- Natural sub-module: bs_tap_fsm, holding the state register plus next-state logic only.
- IR, data registers and output decode stay in the top module.

Test Plan:
- Reset then 5 TMS=1 from RTI -> TapState=F, IrOut=4'b0010, TdoEn=0, ModeControl=0.
- From TLR, TMS 0,1,0,0 then 32 ShDR cycles (TMS=1 on the last) -> TDO streams 32'h1000_0001 LSB first; state ends at Ex1DR(1).
- Load IR=4'b0000 (TMS 0,1,1,0,0, then 4 shift bits, then 1,1) -> first two TDO bits 1,0; after UpdIR ModeControl=1 and IrOut=0.
- With EXTEST active, one CapDR cycle, N ShDR cycles, then UpdDR -> ClockEnBR high for N+1 cycles, ShiftBR high for N cycles, UpdateBR high exactly 1 cycle, TDO follows BsrSO.
- Load BYPASS (4'b1111), shift TDI pattern 1,0,1 -> TDO outputs 0,1,0 (1-cycle delay); ShiftBR and ClockEnBR stay 0.
- RstBar pulled low mid Shift-IR -> TapState=F at once, IR=OP_IDCODE, TdoEn=0; a following Shift-DR returns IDCODE_VAL.
